// File: rtl/net_alu_pkg.sv
// net_alu_pkg: shared qnet ALU types and default widths for the divider and the multiply-accumulate unit
package net_alu_pkg;
    localparam int NET_DW  = 32;
    localparam int NET_BPC = 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mac_state_t;
endpackage

// File: rtl/net_mac_step.sv
// net_mac_step: adds one BPC-bit partial product (a * slice) into the running accumulator
module net_mac_step
    import net_alu_pkg::*;
#(
    parameter int DW  = NET_DW,
    parameter int BPC = NET_BPC
) (
    input  logic [2*DW-1:0] acc_i,
    input  logic [2*DW-1:0] a_i,
    input  logic [BPC-1:0]  b_i,
    output logic [2*DW-1:0] acc_o
);
    // a_i is already shifted to the slice's weight, so the product is added unshifted
    always_comb acc_o = acc_i + a_i * {{(2*DW-BPC){1'b0}}, b_i};
endmodule

// File: rtl/net_mac_r.sv
// net_mac_r: sequential shift-add unsigned A*B+C, BPC multiplier bits per cycle, divider-style start/ready/end handshake
// Optional overflow flag output ovf_o is built when NET_MAC_OVF_EN is defined.
module net_mac_r
    import net_alu_pkg::*;
#(
    parameter int DW  = NET_DW,
    parameter int BPC = NET_BPC
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [DW-1:0]   A_i,
    input  logic [DW-1:0]   B_i,
    input  logic [DW-1:0]   C_i,
    output logic            ready_o,
    output logic            end_o,
    output logic [2*DW-1:0] result_o
`ifdef NET_MAC_OVF_EN
    ,
    output logic            ovf_o
`endif
);
    localparam int N  = DW / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    mac_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*DW-1:0] a_q, a_d, acc_q, acc_d, acc_nxt, result_q, result_d;
    logic [DW-1:0]   b_q, b_d;
    logic            end_q, end_d;
`ifdef NET_MAC_OVF_EN
    logic            ovf_q, ovf_d;
    assign ovf_o = ovf_q;
`endif

    assign ready_o  = (state_q == IDLE) || (state_q == DONE);
    assign end_o    = end_q;
    assign result_o = result_q;

    net_mac_step #(.DW(DW), .BPC(BPC)) u_step (
        .acc_i (acc_q),
        .a_i   (a_q),
        .b_i   (b_q[BPC-1:0]),
        .acc_o (acc_nxt)
    );

    // Next state: load operands on an accepted start, otherwise step the accumulation and publish on the last chunk
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        end_d    = 1'b0;
`ifdef NET_MAC_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (ready_o && start_i) begin
            state_d = RUN;
            a_d     = {{DW{1'b0}}, A_i};
            b_d     = B_i;
            acc_d   = {{DW{1'b0}}, C_i};
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            acc_d = acc_nxt;
            a_d   = a_q << BPC;
            b_d   = b_q >> BPC;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
                state_d  = DONE;
                result_d = acc_nxt;
                end_d    = 1'b1;
`ifdef NET_MAC_OVF_EN
                ovf_d    = |acc_nxt[2*DW-1:DW];
`endif
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset aborts any operation and clears the published result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            end_q    <= 1'b0;
`ifdef NET_MAC_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            end_q    <= end_d;
`ifdef NET_MAC_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_net_mac_r.sv
// tb_net_mac_r: self-checking bench for net_mac_r at BPC=1 and BPC=4, table vectors plus random operands
module tb_net_mac_r;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        st1 = 1'b0, st4 = 1'b0;
    logic [31:0] A = '0, B = '0, C = '0;
    logic        rdy1, rdy4, end1, end4;
    logic [63:0] res1, res4;
    bit          sel = 1'b0;
    int          errs = 0;
    int          checks = 0;
`ifdef NET_MAC_OVF_EN
    logic        ovf1, ovf4, ovf;
    assign ovf = sel ? ovf4 : ovf1;
`endif
    logic        rdy, en;
    logic [63:0] res;
    assign rdy = sel ? rdy4 : rdy1;
    assign en  = sel ? end4 : end1;
    assign res = sel ? res4 : res1;

    always #5 clk = ~clk;

    net_mac_r #(.DW(32), .BPC(1)) u1 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(st1), .A_i(A), .B_i(B), .C_i(C),
        .ready_o(rdy1), .end_o(end1), .result_o(res1)
`ifdef NET_MAC_OVF_EN
        , .ovf_o(ovf1)
`endif
    );
    net_mac_r #(.DW(32), .BPC(4)) u4 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(st4), .A_i(A), .B_i(B), .C_i(C),
        .ready_o(rdy4), .end_o(end4), .result_o(res4)
`ifdef NET_MAC_OVF_EN
        , .ovf_o(ovf4)
`endif
    );

    typedef struct {
        bit          s;
        logic [31:0] a, b, c;
        logic [63:0] exp;
        bit          hold;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: exact unsigned A*B+C in 64 bits
    function automatic logic [63:0] model(input logic [31:0] a, b, c);
        return {32'd0, a} * {32'd0, b} + {32'd0, c};
    endfunction

    task automatic run_op(input bit s, input logic [31:0] a, b, c, input logic [63:0] exp,
                          input bit hold, input string nm);
        int n = s ? 8 : 32;
        int e = 0;
        bit bad_ready = 1'b0;
        sel = s;
        @(negedge clk);
        chk({nm, " ready_idle"}, 64'(rdy), 64'd1);
        A = a; B = b; C = c;
        if (s) st4 = 1'b1; else st1 = 1'b1;
        @(negedge clk);
        if (!hold) begin st1 = 1'b0; st4 = 1'b0; end
        while (!en && e < 200) begin
            A = $urandom; B = $urandom; C = $urandom;
            @(negedge clk);
            e++;
            if (!en && rdy) bad_ready = 1'b1;
        end
        st1 = 1'b0; st4 = 1'b0;
        chk({nm, " latency"}, 64'(e), 64'(n));
        chk({nm, " result"}, res, exp);
        chk({nm, " ready_run_low"}, 64'(bad_ready), 64'd0);
        chk({nm, " ready_done"}, 64'(rdy), 64'd1);
`ifdef NET_MAC_OVF_EN
        chk({nm, " ovf"}, 64'(ovf), 64'(|exp[63:32]));
`endif
        @(negedge clk);
        chk({nm, " end_pulse"}, 64'(en), 64'd0);
        chk({nm, " result_hold"}, res, exp);
    endtask

    initial begin
        int e;
        bit bad;
        logic [31:0] ra, rb, rc;
        tv.push_back('{1'b0, 32'd7, 32'd6, 32'd3, 64'd45, 1'b0});
        tv.push_back('{1'b0, 32'h1234, 32'h100, 32'h56, 64'h123456, 1'b0});
        tv.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b0});
        tv.push_back('{1'b0, 32'd0, $urandom, 32'd5, 64'd5, 1'b0});
        tv.push_back('{1'b0, 32'd11, 32'd13, 32'd2, 64'd145, 1'b1});
        tv.push_back('{1'b1, 32'hFFFF, 32'h10001, 32'd1, 64'h1_0000_0000, 1'b0});
        tv.push_back('{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b0});
        tv.push_back('{1'b1, 32'd7, 32'd6, 32'd3, 64'd45, 1'b1});

        repeat (3) @(negedge clk);
        chk("reset ready1", 64'(rdy1), 64'd1);
        chk("reset end1", 64'(end1), 64'd0);
        chk("reset result1", res1, 64'd0);
        chk("reset result4", res4, 64'd0);
`ifdef NET_MAC_OVF_EN
        chk("reset ovf1", 64'(ovf1), 64'd0);
`endif
        rst_ni = 1'b1;

        foreach (tv[i]) run_op(tv[i].s, tv[i].a, tv[i].b, tv[i].c, tv[i].exp, tv[i].hold,
                               $sformatf("vec%0d", i));

        for (int i = 0; i < 10; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            rc = $urandom;
            run_op(i[0], ra, rb, rc, model(ra, rb, rc), i[1], $sformatf("rnd%0d", i));
        end

        sel = 1'b0;
        @(negedge clk);
        A = 32'd10; B = 32'd20; C = 32'd1; st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0; e = 0;
        while (!end1 && e < 200) begin @(negedge clk); e++; end
        chk("b2b first", res1, 64'd201);
        A = 32'd100; B = 32'd3; C = 32'd0; st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0; e = 1; bad = 1'b0;
        while (!end1 && e < 200) begin
            if (res1 !== 64'd201) bad = 1'b1;
            @(negedge clk);
            e++;
        end
        chk("b2b spacing", 64'(e), 64'd33);
        chk("b2b hold", 64'(bad), 64'd0);
        chk("b2b second", res1, 64'd300);

        @(negedge clk);
        A = 32'hFFFF; B = 32'hFFFF; C = 32'd0; st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst end", 64'(end1), 64'd0);
        chk("rst result", res1, 64'd0);
        chk("rst ready", 64'(rdy1), 64'd1);
        bad = 1'b0;
        repeat (40) begin @(negedge clk); if (end1) bad = 1'b1; end
        chk("rst no_end", 64'(bad), 64'd0);
        rst_ni = 1'b1;
        run_op(1'b0, 32'd3, 32'd5, 32'd0, 64'd15, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
